// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: state encoding and
// default parameter values.
package debounce_pkg;

   localparam int DEF_STABLE_CYCLES = 16;
   localparam int DEF_SYNC_STAGES   = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_STABLE_LO = 2'd0;
   localparam state_t ST_QUAL_HI   = 2'd1;
   localparam state_t ST_STABLE_HI = 2'd2;
   localparam state_t ST_QUAL_LO   = 2'd3;

endpackage

// File: rtl/bit_sync.sv
// Generic single-bit synchronizer: STAGES flops in series, cleared by async
// active-low reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chain_q <= '0;
      else      chain_q <= {chain_q[STAGES-2:0], d};
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debounces a raw asynchronous input: a new level is accepted only after
// STABLE_CYCLES consecutive matching synchronized samples.
module btn_debounce
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int               CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;

   bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (sync)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_STABLE_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   // cnt only ever counts while qualifying; it stops at CNT_MAX because the
   // same edge either commits or aborts.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ST_STABLE_LO: if (sync) begin
            state_d = ST_QUAL_HI;
            cnt_d   = CNT_ONE;
         end
         ST_QUAL_HI: begin
            if (!sync)                 state_d = ST_STABLE_LO;
            else if (cnt_q == CNT_MAX) state_d = ST_STABLE_HI;
            else                       cnt_d   = cnt_q + CNT_ONE;
         end
         ST_STABLE_HI: if (!sync) begin
            state_d = ST_QUAL_LO;
            cnt_d   = CNT_ONE;
         end
         ST_QUAL_LO: begin
            if (sync)                  state_d = ST_STABLE_HI;
            else if (cnt_q == CNT_MAX) state_d = ST_STABLE_LO;
            else                       cnt_d   = cnt_q + CNT_ONE;
         end
         default: state_d = ST_STABLE_LO;
      endcase
   end

   // Outputs are decided from the transition so they register on the same
   // edge as the state change.
   always_comb begin
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (state_q == ST_QUAL_HI && state_d == ST_STABLE_HI) begin
         dout_d = 1'b1;
         rise_d = 1'b1;
      end
      if (state_q == ST_QUAL_LO && state_d == ST_STABLE_LO) begin
         dout_d = 1'b0;
         fall_d = 1'b1;
      end
      busy_d = (state_d == ST_QUAL_HI) || (state_d == ST_QUAL_LO);
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: reset/latency sequences, a segment
// table with hand-derived results, and randomized input against a model.
module tb_btn_debounce;

   localparam int SC = 16;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic rst;
   logic din;
   logic dout, rise, fall, busy;
   logic q_ds;

   always #10 clk = ~clk;

   btn_debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .dout (dout),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   // downstream register fed by the debounced level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q_ds <= 1'b0;
      else      q_ds <= dout;
   end

   int errors = 0;
   int checks = 0;

   // Reference: the block's view of din lags by SS edges; a level is accepted
   // once SC consecutive lagged samples disagree with the current output.
   bit m_dq[$];
   bit m_dout;
   int m_run;
   bit m_rise, m_fall;
   int seg_r, seg_f;

   typedef struct {
      bit d;
      int len;
      int rises;
      int falls;
      bit dout;
      bit busy;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_dq.delete();
      for (int i = 0; i < SS; i++) m_dq.push_back(1'b0);
      m_dout = 1'b0;
      m_run  = 0;
      m_rise = 1'b0;
      m_fall = 1'b0;
   endtask

   task automatic model_step(input bit d);
      bit s;
      s = m_dq.pop_front();
      m_dq.push_back(d);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_dout) begin
         m_run++;
         if (m_run == SC) begin
            m_dout = s;
            m_rise = s;
            m_fall = !s;
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
   endtask

   // Called at a negedge: apply d for one rising edge, compare at the next negedge.
   task automatic step(input bit d, input string tag);
      din = d;
      @(posedge clk);
      model_step(d);
      @(negedge clk);
      check({tag, "_dout"}, dout, m_dout);
      check({tag, "_rise"}, rise, m_rise);
      check({tag, "_fall"}, fall, m_fall);
      check({tag, "_busy"}, busy, (m_run > 0) ? 1 : 0);
      if (rise) seg_r++;
      if (fall) seg_f++;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected end before 2 ms");
      $fatal(1);
   end

   initial begin
      int rise_edge;
      int len;
      bit d;

      tbl[0]  = '{1'b1, 10, 0, 0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 30, 0, 0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 17, 0, 0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1,  5, 1, 0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 15, 0, 0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1,  1, 0, 0, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 17, 0, 0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0,  2, 0, 1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 20, 0, 0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 18, 1, 0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 18, 0, 1, 1'b0, 1'b0};

      // reset held 100 ns with din high
      din = 1'b1;
      rst = 1'b0;
      model_reset();
      repeat (5) begin
         @(negedge clk);
         check("rst_dout", dout, 0);
         check("rst_rise", rise, 0);
         check("rst_fall", fall, 0);
         check("rst_busy", busy, 0);
      end
      rst = 1'b1;
      rise_edge = -1;
      for (int e = 1; e <= 40 && rise_edge < 0; e++) begin
         step(1'b1, "rel");
         if (rise) rise_edge = e;
      end
      check("rel_rise_edge", rise_edge, SS + SC);
      check("rel_ds_before", q_ds, 0);
      step(1'b1, "rel");
      check("rel_ds_after", q_ds, 1);

      // return to idle low before the table
      for (int i = 0; i < 30; i++) step(1'b0, "idle");
      check("idle_dout", dout, 0);

      for (int v = 0; v < 11; v++) begin
         seg_r = 0;
         seg_f = 0;
         for (int i = 0; i < tbl[v].len; i++) step(tbl[v].d, $sformatf("tbl%0d", v));
         check($sformatf("tbl%0d_rises", v), seg_r, tbl[v].rises);
         check($sformatf("tbl%0d_falls", v), seg_f, tbl[v].falls);
         check($sformatf("tbl%0d_dout", v), dout, tbl[v].dout);
         check($sformatf("tbl%0d_busy", v), busy, tbl[v].busy);
      end

      // reset in the middle of qualification (cnt = 8)
      for (int i = 0; i < 10; i++) step(1'b1, "mid");
      check("mid_busy_pre", busy, 1);
      #5 rst = 1'b0;
      #1;
      check("mid_clr_busy", busy, 0);
      check("mid_clr_dout", dout, 0);
      check("mid_clr_rise", rise, 0);
      check("mid_clr_fall", fall, 0);
      model_reset();
      @(negedge clk);
      check("mid_hold_busy", busy, 0);
      #15 rst = 1'b1;
      @(negedge clk);
      seg_r = 0;
      seg_f = 0;
      rise_edge = -1;
      for (int e = 1; e <= 40 && rise_edge < 0; e++) begin
         step(1'b1, "mid");
         if (rise) rise_edge = e;
      end
      check("mid_rise_edge", rise_edge, SS + SC);
      check("mid_rise_count", seg_r, 1);
      check("mid_fall_count", seg_f, 0);

      // randomized segments, mostly short glitches with some long holds
      for (int s = 0; s < 150; s++) begin
         d   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 40) : $urandom_range(1, 20);
         for (int i = 0; i < len; i++) step(d, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
